// File: rtl/dmem_resp_pkg.sv
// mips_def: shared definitions for the MIPS data-memory responder.
//   dmem_state_t   : responder FSM state encoding (idle / wait-state / response)
//   DMEM_WAIT_MAX  : largest legal wait-state count (4-bit counter)
//   DMEM_WORD_W    : data word width
package mips_def;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_WAIT_MAX = 15;
  localparam int DMEM_WORD_W   = 32;

endpackage

// File: rtl/dmem_resp_sram.sv
// dmem_sram: single-port synchronous word array.
//   clk   : clock
//   we    : write enable, writes wdata to addr on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read data of addr, one cycle after the address edge;
//           a read at the address being written returns the old word.
// Contents are not reset.
module dmem_sram
  import mips_def::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);

  logic [DMEM_WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the MEM-stage load/store port.
// Accepts one word read or write, holds it for WAIT wait states, then
// completes it with a single-cycle mem_ready pulse.
//
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   mem_addr      : byte address of the request (index = addr[ADDR_W+1:2])
//   mem_wdata     : store data
//   mem_rd/mem_wr : load / store request (both high = store)
//   mem_rdata     : load data, valid while mem_ready=1 for a load; holds the
//                   last load result otherwise
//   mem_ready     : one-cycle completion pulse
//   mem_err       : misaligned-access flag, valid with mem_ready
//   dbg_state     : current FSM state (dmem_state_t encoding)
//
// Configuration: define DMEM_MISALIGN_CHK_EN to flag accesses with
// addr[1:0]!=0 via mem_err, suppress misaligned stores and return 0 for
// misaligned loads. Undefined: addr[1:0] is ignored and mem_err is 0.
//
// Handshake: the requester raises mem_rd/mem_wr and holds it until it sees
// mem_ready. A request is captured only at an edge where the FSM is idle;
// inputs after capture are ignored. The response occupies exactly one cycle
// and is always followed by at least one idle cycle before the next capture.
module dmem_resp
  import mips_def::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            mem_addr,
  input  logic [DMEM_WORD_W-1:0] mem_wdata,
  input  logic                   mem_rd,
  input  logic                   mem_wr,
  output logic [DMEM_WORD_W-1:0] mem_rdata,
  output logic                   mem_ready,
  output logic                   mem_err,
  output logic [1:0]             dbg_state
);

  // Counter preload; WAIT beyond DMEM_WAIT_MAX is not supported by the 4-bit counter.
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  dmem_state_t            state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [DMEM_WORD_W-1:0] wdata_q, wdata_d;
  logic                   is_wr_q, is_wr_d;
  logic                   mis_q, mis_d;
  logic [DMEM_WORD_W-1:0] rdata_hold_q, rdata_hold_d;

  logic                   req_mis;
  logic                   sram_we;
  logic [DMEM_WORD_W-1:0] sram_rdata;
  logic [DMEM_WORD_W-1:0] load_data;
  logic                   unused_addr;

  assign unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

`ifdef DMEM_MISALIGN_CHK_EN
  assign req_mis = (mem_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  assign load_data = mis_q ? '0 : sram_rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    is_wr_d      = is_wr_q;
    mis_d        = mis_q;
    rdata_hold_d = rdata_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_rd || mem_wr) begin
          idx_d   = mem_addr[ADDR_W+1:2];
          wdata_d = mem_wdata;
          is_wr_d = mem_wr;
          mis_d   = req_mis;
          if (WAIT > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        // Latch the load result so mem_rdata keeps it after the pulse.
        if (!is_wr_q) begin
          rdata_hold_d = load_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      idx_q        <= '0;
      wdata_q      <= '0;
      is_wr_q      <= 1'b0;
      mis_q        <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      is_wr_q      <= is_wr_d;
      mis_q        <= mis_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  // Store commits on the edge leaving RESP; gating with rst drops a store
  // whose final edge coincides with reset.
  assign sram_we = rst && (state_q == ST_RESP) && is_wr_q && !mis_q;

  // The array is addressed with idx_d so that with WAIT=0 the read on the
  // capture edge already uses the newly captured index.
  dmem_sram #(
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (idx_d),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  assign mem_ready = (state_q == ST_RESP);
  assign mem_rdata = (mem_ready && !is_wr_q) ? load_data : rdata_hold_q;
  assign dbg_state = state_q;

`ifdef DMEM_MISALIGN_CHK_EN
  assign mem_err = mem_ready && mis_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: one instance with WAIT=2 (index 0) and one with
// WAIT=0 (index 1) sharing clock and reset. Expected {mem_err, mem_rdata}
// is pushed into exp_q when a request is driven and popped at mem_ready.
module tb_dmem_resp;

  localparam int ADDR_W = 10;
  localparam int W0     = 2;
  localparam int W1     = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];
  logic        rd_i    [2];
  logic        wr_i    [2];
  logic [31:0] rdata_o [2];
  logic        ready_o [2];
  logic        err_o   [2];
  logic [1:0]  st_o    [2];

  dmem_resp #(.ADDR_W(ADDR_W), .WAIT(W0)) dut (
    .clk(clk), .rst(rst), .mem_addr(addr_i[0]), .mem_wdata(wdata_i[0]),
    .mem_rd(rd_i[0]), .mem_wr(wr_i[0]), .mem_rdata(rdata_o[0]),
    .mem_ready(ready_o[0]), .mem_err(err_o[0]), .dbg_state(st_o[0])
  );

  dmem_resp #(.ADDR_W(ADDR_W), .WAIT(W1)) dut_w0 (
    .clk(clk), .rst(rst), .mem_addr(addr_i[1]), .mem_wdata(wdata_i[1]),
    .mem_rd(rd_i[1]), .mem_wr(wr_i[1]), .mem_rdata(rdata_o[1]),
    .mem_ready(ready_o[1]), .mem_err(err_o[1]), .dbg_state(st_o[1])
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [int];
  logic [31:0] last_load [2];
  logic [32:0] exp_q [$];

  function automatic int key_of(input int which, input logic [31:0] a);
    return which * 4096 + int'(a[ADDR_W+1:2]);
  endfunction

  function automatic int wait_of(input int which);
    return (which == 0) ? W0 : W1;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Entered and left at a negedge. exp_lat counts negedges from driving the
  // request to seeing mem_ready.
  task automatic run_access(input int which, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int exp_lat, input string name);
    logic        mis;
    logic [31:0] v;
    logic [32:0] exp_v;
    logic [32:0] got;
    int          n;
    bit          seen;
`ifdef DMEM_MISALIGN_CHK_EN
    mis = (addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (wr) begin
      exp_q.push_back({mis, last_load[which]});
      if (!mis) mdl[key_of(which, addr)] = wdata;
    end else begin
      v = mis ? 32'h0 : mdl[key_of(which, addr)];
      last_load[which] = v;
      exp_q.push_back({mis, v});
    end
    rd_i[which]    = rd;
    wr_i[which]    = wr;
    addr_i[which]  = addr;
    wdata_i[which] = wdata;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (ready_o[which] === 1'b1) seen = 1'b1;
    end
    rd_i[which] = 1'b0;
    wr_i[which] = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no mem_ready within 40 cycles (dut %0d)", name, which);
    end else if (n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, exp_lat);
    end
    if (seen) begin
      checks++;
      got = {err_o[which], rdata_o[which]};
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s data: got err=%b rdata=%h, expected err=%b rdata=%h",
                 name, got[32], got[31:0], exp_v[32], exp_v[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_i[i] = 1'b0; wr_i[i] = 1'b0; addr_i[i] = '0; wdata_i[i] = '0;
      last_load[i] = '0;
    end
    idle(3);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ready_o[i] !== 1'b0 || err_o[i] !== 1'b0 || rdata_o[i] !== 32'h0 || st_o[i] !== 2'd0) begin
          errors++;
          $display("FAIL reset_idle dut %0d: ready=%b err=%b rdata=%h state=%0d, expected 0 0 0 0",
                   i, ready_o[i], err_o[i], rdata_o[i], st_o[i]);
        end
      end
    end
  endtask

  task automatic test_store_load();
    idle(1);
    run_access(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, W0 + 1, "store_40");
    idle(1);
    run_access(0, 1'b1, 1'b0, 32'h40, 32'h0, W0 + 1, "load_40");
  endtask

  task automatic test_back_to_back();
    idle(1);
    run_access(1, 1'b0, 1'b1, 32'h0, 32'h01010101, W1 + 1, "w0_store_0");
    idle(1);
    run_access(1, 1'b0, 1'b1, 32'h4, 32'h02020202, W1 + 1, "w0_store_4");
    idle(1);
    run_access(1, 1'b1, 1'b0, 32'h0, 32'h0, W1 + 1, "w0_load_0");
    run_access(1, 1'b1, 1'b0, 32'h4, 32'h0, W1 + 2, "w0_load_4_b2b");
    checks++;
    @(negedge clk);
    if (ready_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL w0_ready_pulse: ready=%b in cycle after response, expected 0", ready_o[1]);
    end
    run_access(0, 1'b1, 1'b0, 32'h40, 32'h0, W0 + 1, "w2_load_40");
    run_access(0, 1'b1, 1'b1, 32'h44, 32'h44445555, W0 + 2, "w2_rdwr_b2b");
    run_access(0, 1'b1, 1'b0, 32'h44, 32'h0, W0 + 2, "w2_load_44_b2b");
  endtask

  task automatic test_alias();
    idle(1);
    run_access(0, 1'b0, 1'b1, 32'h1000, 32'h12345678, W0 + 1, "alias_store_1000");
    idle(1);
    run_access(0, 1'b1, 1'b0, 32'h0, 32'h0, W0 + 1, "alias_load_0");
  endtask

  task automatic test_reset_abort();
    int seen_ready;
    idle(1);
    run_access(0, 1'b0, 1'b1, 32'h80, 32'h0BADF00D, W0 + 1, "abort_prefill_80");
    idle(1);
    wr_i[0] = 1'b1; addr_i[0] = 32'h80; wdata_i[0] = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    wr_i[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_load[0] = '0;
    last_load[1] = '0;
    seen_ready = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ready_o[0] === 1'b1 || ready_o[1] === 1'b1) seen_ready++;
    end
    checks++;
    if (seen_ready != 0) begin
      errors++;
      $display("FAIL abort_no_ready: mem_ready seen %0d cycles after reset, expected 0", seen_ready);
    end
    checks++;
    if (rdata_o[0] !== 32'h0 || st_o[0] !== 2'd0) begin
      errors++;
      $display("FAIL abort_state: rdata=%h state=%0d, expected 0 and 0", rdata_o[0], st_o[0]);
    end
    run_access(0, 1'b1, 1'b0, 32'h80, 32'h0, W0 + 1, "abort_load_80");
  endtask

  task automatic test_misalign();
    idle(1);
    run_access(0, 1'b0, 1'b1, 32'h82, 32'h11111111, W0 + 1, "mis_store_82");
    idle(1);
    run_access(0, 1'b1, 1'b0, 32'h80, 32'h0, W0 + 1, "mis_load_80");
    idle(1);
    run_access(0, 1'b1, 1'b0, 32'h83, 32'h0, W0 + 1, "mis_load_83");
    idle(1);
    run_access(1, 1'b1, 1'b0, 32'h5, 32'h0, W1 + 1, "mis_w0_load_5");
  endtask

  task automatic test_random();
    int          prev;
    int          which;
    int          lat;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 8; k++) begin
        idle(1);
        run_access(w, 1'b0, 1'b1, 32'h100 + 32'(4 * k), $urandom, wait_of(w) + 1, "rnd_fill");
      end
    end
    prev = 1;
    for (int t = 0; t < 24; t++) begin
      which = int'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      rd    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      addr  = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) addr = addr + 32'h1000;
      if (which == prev && $urandom_range(0, 1) == 1) begin
        lat = wait_of(which) + 2;
      end else begin
        idle(1);
        lat = wait_of(which) + 1;
      end
      run_access(which, rd, wr, addr, $urandom, lat, "rnd_access");
      prev = which;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_alias();
    test_reset_abort();
    test_misalign();
    test_random();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
